// File: rtl/mips_muldiv_unit_if.sv
// Handshake and data bundle between the execute stage and the multiply/divide unit.
// The issuing pipeline drives the request side (master); the unit drives status and HI/LO (slave).
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is restored in a single FIX cycle,
// so every mult/div takes exactly WIDTH+1 cycles from the accepting edge to done.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    mips_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               q_neg_q;    // product / quotient must be negated
    logic               r_neg_q;    // remainder must be negated (dividend was negative)
    logic               dbz_q;      // divide by zero: quotient forced to all-ones
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic load_en, iter_en, write_en;

    // Request decode: flush in IDLE suppresses any simultaneous start.
    logic idle, req_ok, start_md, start_mthi, start_mtlo;
    assign idle       = (state_q == S_IDLE);
    assign req_ok     = idle && bus.start && !bus.flush;
    assign start_md   = req_ok && (bus.op == OP_MULT || bus.op == OP_MULTU ||
                                   bus.op == OP_DIV  || bus.op == OP_DIVU);
    assign start_mthi = req_ok && (bus.op == OP_MTHI);
    assign start_mtlo = req_ok && (bus.op == OP_MTLO);

    // Operand preparation: magnitudes for signed ops, raw values for unsigned.
    logic             op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign a_neg     = op_signed && bus.rs_data[WIDTH-1];
    assign b_neg     = op_signed && bus.rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -bus.rs_data : bus.rs_data;
    assign b_mag     = b_neg ? -bus.rt_data : bus.rt_data;

    // One shift-add multiply step: add multiplicand when the low multiplier bit is set.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step: shift in a dividend bit, keep the subtraction if it did not borrow.
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, opb_q};
    assign div_next  = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign correction applied in FIX before HI/LO are written.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
    assign prod_fix = q_neg_q ? -acc_q : acc_q;
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div_q ? (dbz_q ? '1 : (q_neg_q ? -quo : quo)) : prod_fix[WIDTH-1:0];
    assign fix_hi   = is_div_q ? (r_neg_q ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];

    // FSM next state and datapath enables.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        load_en  = 1'b0;
        iter_en  = 1'b0;
        write_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_md) begin
                    state_d = S_CALC;
                    load_en = 1'b1;
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    iter_en = 1'b1;
                    if (count_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d  = S_IDLE;
                write_en = !bus.flush;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (load_en) begin
            count_q  <= CW'(WIDTH);
            acc_q    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
            opb_q    <= op_div ? b_mag : a_mag;
            is_div_q <= op_div;
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            dbz_q    <= (bus.rt_data == '0);
        end else if (iter_en) begin
            count_q <= count_q - CW'(1);
            acc_q   <= is_div_q ? div_next : mul_next;
        end
    end

    // Architectural HI/LO: written by FIX or by MTHI/MTLO in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (write_en) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if (start_mthi) begin
            hi_q <= bus.rs_data;
        end else if (start_mtlo) begin
            lo_q <= bus.rs_data;
        end
    end

    // Completion pulse in the cycle following the FIX edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= write_en;
    end

    assign bus.busy = !idle;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, in parallel with the single-cycle ALU.
- Consumes the two register-file read operands and owns the architectural HI/LO registers.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with a start/busy/done handshake.
- MFHI/MFLO read the hi/lo outputs directly; the control path stalls issue while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled on rising clk edge, only honoured when busy=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- rs_data  in  WIDTH  operand A (multiplicand/dividend; MTHI/MTLO source)
- rt_data  in  WIDTH  operand B (multiplier/divisor)
- flush  in  1  synchronous cancel of an in-flight operation
- busy  out  1  high while a mult/div is in progress
- done  out  1  one-cycle pulse when HI/LO are updated by a mult/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0.
  - State returns to IDLE and internal accumulators clear.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE with start=1 and op in MULT/MULTU/DIV/DIVU:
  - Latch operands; for signed ops, store magnitudes plus result-sign flags.
  - Load counter=WIDTH and go to CALC; busy=1 from the next cycle.
- IDLE with start=1 and op=MTHI/MTLO:
  - hi (or lo) <= rs_data at that edge.
  - busy stays 0 and done stays 0.
- IDLE with start=1 and op=11x: no effect.
- CALC: one iteration per cycle, WIDTH cycles total.
  - Multiply: shift-add on a 2*WIDTH product register.
  - Divide: restoring shift-subtract.
  - After the last iteration, go to FIX.
- FIX (one cycle):
  - Apply sign correction, then write {hi,lo}.
  - Multiply: hi=product[63:32], lo=product[31:0].
  - Divide: lo=quotient, hi=remainder.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - done=1 in the cycle after the FIX edge; busy=0 in that same cycle.
- Latency: start sampled at edge E0 -> hi/lo valid and done=1 after edge E(WIDTH+1), i.e. E33 for WIDTH=32.
- Latency is fixed for every mult/div op, including the special cases below.
- Divide by zero (rt_data=0): runs full latency; lo=all-ones, hi=rs_data.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- start while busy=1: ignored, including MTHI/MTLO; the requester must hold or retry.
- flush=1:
  - In CALC or FIX: return to IDLE next edge; hi/lo unchanged; no done; busy=0 next cycle.
  - In IDLE: flush wins over a simultaneous start.
- hi/lo change only on FIX, MTHI/MTLO or reset.
- Back-to-back: start may be asserted in the cycle done=1 (busy=0); it is accepted at that edge.

Test Plan:
- Reset then MULTU rs=0xFFFFFFFF, rt=0x00000002 -> done after 33 cycles; hi=0x00000001, lo=0xFFFFFFFE; busy high for exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; both cases with the normal 33-cycle latency.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 in consecutive cycles -> hi/lo updated on each respective edge; busy and done never assert.
- Start DIVU 50/7; in cycle 10 assert start with MTHI 0xAAAA and separately pulse flush in cycle 15 -> MTHI ignored, hi/lo keep their prior values, no done, busy=0 at cycle 16; a new MULTU 6*7 is accepted next -> lo=42, hi=0.
- Assert rst_n=0 asynchronously mid-CALC -> hi=lo=0 and busy=done=0 immediately; after release, a subsequent MULTU 3*4 gives lo=12 at full latency.
